// File: rtl/training_sequencer.sv
// training_sequencer
//
// Buffers up to DEPTH labelled training samples (an N-lane input vector plus a
// target value) and replays them EPOCHS times into a downstream neuron_learn
// block. Each sample is presented for SETTLE cycles with learn=0 and then
// held for one learn cycle. neuron_valid stays high from the first present
// cycle to the last learn cycle so the neuron never sees a valid gap
// mid-training.
//
// zero2one_t values (fractions in [0,1]) are carried as unsigned DataW-bit
// codes.
//
// Ports:
//   _trigger            clock; all state changes on its rising edge
//   _reset              synchronous, active-high reset
//   sample_valid        write request
//   sample_ready        buffer accepts a write this cycle (from registers only)
//   sample_in           N-lane sample vector
//   sample_expected     sample target
//   clear               empty the buffer (honoured in idle only)
//   start               begin training (honoured in idle only)
//   busy                high while presenting or learning
//   done                one-cycle pulse at the end of training
//   count               number of stored samples
//   epoch               current pass, 0-based
//   index               current sample slot
//   neuron_in           to neuron_learn.in
//   neuron_expected_out to neuron_learn.expected_out
//   neuron_valid        to neuron_learn.valid
//   neuron_learn        to neuron_learn.learn
module training_sequencer #(
  parameter int unsigned N      = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned EPOCHS = 4,
  parameter int unsigned DataW  = 8,
  localparam int unsigned CntW  = $clog2(DEPTH + 1),
  localparam int unsigned EpW   = $clog2(EPOCHS + 1),
  localparam int unsigned IdxW  = $clog2(DEPTH),
  localparam int unsigned StlW  = $clog2(SETTLE + 1)
) (
  input  logic                       _trigger,
  input  logic                       _reset,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [N-1:0][DataW-1:0]    sample_in,
  input  logic [DataW-1:0]           sample_expected,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [CntW-1:0]            count,
  output logic [EpW-1:0]             epoch,
  output logic [IdxW-1:0]            index,
  output logic [N-1:0][DataW-1:0]    neuron_in,
  output logic [DataW-1:0]           neuron_expected_out,
  output logic                       neuron_valid,
  output logic                       neuron_learn
);

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StLearn,
    StDone
  } state_e;

  // Sample buffer; contents are don't-care after reset, so no reset is applied.
  logic [N-1:0][DataW-1:0] mem_in_q  [DEPTH];
  logic [DataW-1:0]        mem_exp_q [DEPTH];

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [EpW-1:0]          epoch_q, epoch_d;
  logic [IdxW-1:0]         index_q, index_d;
  logic [StlW-1:0]         settle_q, settle_d;
  logic [N-1:0][DataW-1:0] nin_q, nin_d;
  logic [DataW-1:0]        nexp_q, nexp_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    learn_q, learn_d;

  logic                    wr_en;
  logic                    more_samples;
  logic                    more_epochs;
  logic                    settle_last;
  logic                    load;
  logic [IdxW-1:0]         idx_inc;
  logic [IdxW-1:0]         rd_slot;
  logic                    rd_bypass;
  logic [N-1:0][DataW-1:0] rd_in;
  logic [DataW-1:0]        rd_exp;

  assign sample_ready = (state_q == StIdle) && (32'(count_q) < DEPTH);

  // clear beats a same-cycle write: the sample is discarded.
  assign wr_en = sample_valid && sample_ready && !clear;

  assign idx_inc      = index_q + IdxW'(1);
  assign more_samples = (CntW'(index_q) + CntW'(1)) < count_q;
  assign more_epochs  = (32'(epoch_q) + 32'd1) < EPOCHS;
  assign settle_last  = (32'(settle_q) + 32'd1) == SETTLE;

  // Slot that the next present phase loads from. Only a learn cycle with
  // samples left advances it; idle-start and epoch wrap both read slot 0.
  assign rd_slot = (state_q == StLearn && more_samples) ? idx_inc : '0;

  // A sample written in the same cycle as start may be the one loaded first
  // (empty buffer plus write), so forward it past the buffer.
  assign rd_bypass = wr_en && (count_q[IdxW-1:0] == rd_slot);
  assign rd_in     = rd_bypass ? sample_in       : mem_in_q[rd_slot];
  assign rd_exp    = rd_bypass ? sample_expected : mem_exp_q[rd_slot];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    epoch_d  = epoch_q;
    index_d  = index_q;
    settle_d = settle_q;
    load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d = '0;
        end else if (wr_en) begin
          count_d = count_q + CntW'(1);
        end
        // Decision uses the post-clear/post-write count.
        if (start) begin
          if (count_d == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StPresent;
            epoch_d  = '0;
            index_d  = '0;
            settle_d = '0;
            load     = 1'b1;
          end
        end
      end
      StPresent: begin
        if (settle_last) begin
          state_d  = StLearn;
          settle_d = '0;
        end else begin
          settle_d = settle_q + StlW'(1);
        end
      end
      StLearn: begin
        if (more_samples) begin
          state_d = StPresent;
          index_d = idx_inc;
          load    = 1'b1;
        end else if (more_epochs) begin
          state_d = StPresent;
          epoch_d = epoch_q + EpW'(1);
          index_d = '0;
          load    = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Neuron data changes only on entry to a present phase.
    nin_d  = load ? rd_in  : nin_q;
    nexp_d = load ? rd_exp : nexp_q;

    // Outputs are registered copies decoded from the next state.
    busy_d  = (state_d == StPresent) || (state_d == StLearn);
    valid_d = busy_d;
    learn_d = (state_d == StLearn);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge _trigger) begin
    if (_reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      epoch_q  <= '0;
      index_q  <= '0;
      settle_q <= '0;
      nin_q    <= '0;
      nexp_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      learn_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      epoch_q  <= epoch_d;
      index_q  <= index_d;
      settle_q <= settle_d;
      nin_q    <= nin_d;
      nexp_q   <= nexp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      learn_q  <= learn_d;
    end
  end

  always_ff @(posedge _trigger) begin
    if (wr_en) begin
      mem_in_q[count_q[IdxW-1:0]]  <= sample_in;
      mem_exp_q[count_q[IdxW-1:0]] <= sample_expected;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign count               = count_q;
  assign epoch               = epoch_q;
  assign index               = index_q;
  assign neuron_in           = nin_q;
  assign neuron_expected_out = nexp_q;
  assign neuron_valid        = valid_q;
  assign neuron_learn        = learn_q;

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge _trigger) disable iff (_reset)
    32'(count_q) <= DEPTH);
  a_learn_valid : assert property (@(posedge _trigger) disable iff (_reset)
    learn_q |-> valid_q);
  a_busy_valid : assert property (@(posedge _trigger) disable iff (_reset)
    busy_q == valid_q);
  a_done_idle : assert property (@(posedge _trigger) disable iff (_reset)
    done_q |-> !busy_q);
`endif

endmodule

// File: tb/tb_training_sequencer.sv
// Self-checking bench for training_sequencer. A queue-free array model holds
// the stored samples; the expected training trace is derived arithmetically
// from the cycle number (epoch, slot and phase) rather than from any state.
module tb_training_sequencer;

  localparam int unsigned N      = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned EPOCHS = 2;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned IW     = $clog2(DEPTH);
  localparam int unsigned EW     = $clog2(EPOCHS + 1);

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  vec_t          sample_in = '0;
  logic [DW-1:0] sample_expected = '0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic [EW-1:0] epoch;
  logic [IW-1:0] index;
  vec_t          neuron_in;
  logic [DW-1:0] neuron_expected_out;
  logic          neuron_valid;
  logic          neuron_learn;

  int tests = 0;
  int fails = 0;

  // Reference model
  vec_t          m_in  [DEPTH];
  logic [DW-1:0] m_exp [DEPTH];
  int            model_count = 0;
  vec_t          last_in = '0;
  logic [DW-1:0] last_exp = '0;

  training_sequencer #(
    .N      (N),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE),
    .EPOCHS (EPOCHS),
    .DataW  (DW)
  ) dut (
    ._trigger            (clk),
    ._reset              (rst),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready),
    .sample_in           (sample_in),
    .sample_expected     (sample_expected),
    .clear               (clear),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .count               (count),
    .epoch               (epoch),
    .index               (index),
    .neuron_in           (neuron_in),
    .neuron_expected_out (neuron_expected_out),
    .neuron_valid        (neuron_valid),
    .neuron_learn        (neuron_learn)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_sample(output vec_t v, output logic [DW-1:0] e);
    for (int j = 0; j < N; j++) v[j] = DW'($urandom);
    e = DW'($urandom);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sample_valid = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    tick();
    rst = 1'b0;
    model_count = 0;
    last_in = '0;
    last_exp = '0;
  endtask

  // One write attempt; acceptance is predicted from the model's fill level.
  task automatic write_sample;
    vec_t          v;
    logic [DW-1:0] e;
    bit            acc;
    rand_sample(v, e);
    acc = (model_count < DEPTH);
    sample_in = v;
    sample_expected = e;
    sample_valid = 1'b1;
    tests++;
    if (sample_ready !== acc) begin
      fails++;
      $display("FAIL write_ready: got %b want %b (count %0d)", sample_ready, acc, model_count);
    end
    tick();
    sample_valid = 1'b0;
    if (acc) begin
      m_in[model_count]  = v;
      m_exp[model_count] = e;
      model_count++;
    end
    tests++;
    if (count !== CW'(model_count)) begin
      fails++;
      $display("FAIL write_count: got %0d want %0d", count, model_count);
    end
  endtask

  task automatic clear_buffer;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_count = 0;
    tests++;
    if (count !== '0) begin
      fails++;
      $display("FAIL clear_count: got %0d want 0", count);
    end
  endtask

  // Issue start (optionally with a same-cycle write and/or clear) and check
  // every cycle until back in idle. glitch pulses start+clear while busy.
  task automatic train(input bit do_write, input bit do_clear, input bit glitch);
    vec_t                 wv;
    logic [DW-1:0]        we;
    int                   cnt, per, len, e, s, ph;
    logic [3+IW+EW:0]     exp_ctl;
    rand_sample(wv, we);
    sample_in = wv;
    sample_expected = we;
    sample_valid = do_write;
    clear = do_clear;
    start = 1'b1;
    if (do_clear) begin
      model_count = 0;
    end else if (do_write && model_count < DEPTH) begin
      m_in[model_count]  = wv;
      m_exp[model_count] = we;
      model_count++;
    end
    tick();
    sample_valid = 1'b0;
    clear = 1'b0;
    start = 1'b0;

    cnt = model_count;
    per = SETTLE + 1;
    len = cnt * EPOCHS * per;
    for (int k = 0; k < len; k++) begin
      e  = k / (cnt * per);
      s  = (k / per) % cnt;
      ph = k % per;
      exp_ctl = {1'b1, 1'b0, 1'b1, (ph == SETTLE), IW'(s), EW'(e)};
      tests++;
      if ({busy, done, neuron_valid, neuron_learn, index, epoch} !== exp_ctl) begin
        fails++;
        $display("FAIL train_ctl cycle %0d: got %b want %b", k,
                 {busy, done, neuron_valid, neuron_learn, index, epoch}, exp_ctl);
      end
      tests++;
      if (neuron_in !== m_in[s] || neuron_expected_out !== m_exp[s]) begin
        fails++;
        $display("FAIL train_data cycle %0d: got %h/%h want %h/%h", k,
                 neuron_in, neuron_expected_out, m_in[s], m_exp[s]);
      end
      last_in  = m_in[s];
      last_exp = m_exp[s];
      start = glitch && (k == 1);
      clear = glitch && (k == 1);
      tick();
    end
    start = 1'b0;
    clear = 1'b0;

    tests++;
    if ({busy, done, neuron_valid, neuron_learn} !== 4'b0100) begin
      fails++;
      $display("FAIL done_cycle: got bdvl=%b want 0100",
               {busy, done, neuron_valid, neuron_learn});
    end
    tests++;
    if (neuron_in !== last_in || neuron_expected_out !== last_exp) begin
      fails++;
      $display("FAIL done_hold: got %h/%h want %h/%h", neuron_in, neuron_expected_out,
               last_in, last_exp);
    end
    tick();
    tests++;
    if ({busy, done, neuron_valid, neuron_learn} !== 4'b0000 ||
        sample_ready !== (model_count < DEPTH) || count !== CW'(model_count)) begin
      fails++;
      $display("FAIL idle_after: got bdvl=%b rdy=%b cnt=%0d want 0000 %b %0d",
               {busy, done, neuron_valid, neuron_learn}, sample_ready, count,
               (model_count < DEPTH), model_count);
    end
    tick();
    tests++;
    if (neuron_in !== last_in || neuron_expected_out !== last_exp || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: got %h/%h done=%b want %h/%h done=0", neuron_in,
               neuron_expected_out, done, last_in, last_exp);
    end
  endtask

  task automatic test_reset;
    do_reset();
    tests++;
    if ({busy, done, neuron_valid, neuron_learn, count, epoch, index} !== '0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 0",
               {busy, done, neuron_valid, neuron_learn, count, epoch, index});
    end
    tests++;
    if (neuron_in !== '0 || neuron_expected_out !== '0 || sample_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_data: got %h/%h rdy=%b want 0/0 rdy=1", neuron_in,
               neuron_expected_out, sample_ready);
    end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_sample();
    tests++;
    if (sample_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      fails++;
      $display("FAIL fill_full: got rdy=%b cnt=%0d want rdy=0 cnt=%0d", sample_ready, count,
               DEPTH);
    end
    write_sample();  // dropped
  endtask

  task automatic test_cadence;
    do_reset();
    for (int i = 0; i < 3; i++) write_sample();
    train(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_start;
    do_reset();
    train(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle;
    do_reset();
    write_sample();
    train(1'b1, 1'b0, 1'b0);  // write + start: two samples per epoch
    train(1'b1, 1'b1, 1'b0);  // clear + start: empty path
    for (int i = 0; i < 3; i++) write_sample();
    train(1'b0, 1'b0, 1'b1);  // start/clear while busy are ignored
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 4; i++) write_sample();
    train(1'b0, 1'b0, 1'b0);
    train(1'b0, 1'b0, 1'b0);  // reissued start over the retained buffer
  endtask

  task automatic test_mid_reset;
    int  waited;
    bit  saw_done;
    do_reset();
    for (int i = 0; i < 4; i++) write_sample();
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (epoch !== EW'(1) && waited < 200) begin
      tick();
      waited++;
    end
    tests++;
    if (epoch !== EW'(1)) begin
      fails++;
      $display("FAIL mid_reset_wait: got epoch %0d want 1", epoch);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_count = 0;
    tests++;
    if ({busy, done, neuron_valid, neuron_learn, count, epoch, index} !== '0 ||
        neuron_in !== '0 || neuron_expected_out !== '0 || sample_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: got ctl=%b data=%h/%h rdy=%b want 0 0/0 rdy=1",
               {busy, done, neuron_valid, neuron_learn, count, epoch, index}, neuron_in,
               neuron_expected_out, sample_ready);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL mid_reset_quiet: got done/busy activity want none");
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 5; r++) begin
      int n;
      clear_buffer();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_sample();
      train(($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_cadence();
    test_empty_start();
    test_same_cycle();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
